// File: rtl/seg7_pkg.sv
// Purpose: shared glyph constants, glyph lookup and scan FSM state type for the 7-seg scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    // Decimal glyphs for 0-9; any non-decimal nibble renders as '-'.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
        logic [6:0] g;
        case (nibble)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// Purpose: groups the BCD load path and the display drive lines of the scanner.
// Latency: n/a (wiring only).
// Backpressure: none; bcd_valid is a fire-and-forget strobe.
interface bcd_seg7_scan_if;
    import seg7_pkg::*;

    logic [15:0] bcd;
    logic        bcd_valid;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    // Producer of the BCD word and display options; observes the display lines.
    modport master (
        output bcd, bcd_valid, blank_lz, dp_mask,
        input  an, seg, dp
    );

    // The scanner itself.
    modport slave (
        input  bcd, bcd_valid, blank_lz, dp_mask,
        output an, seg, dp
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Purpose: one BCD nibble to active-low 7-segment pattern, with forced blank.
// Latency: combinational.
// Backpressure: none.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the glyph so leading-zero suppression can reuse this path.
    always_comb begin
        seg = blank ? SEG_BLANK : seg7_glyph(nibble);
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Purpose: latch a 4-digit packed BCD word and scan it onto a common-anode 7-seg display.
// Latency: load visible on outputs two edges after the strobe edge; outputs are registered.
// Backpressure: none; every bcd_valid strobe overwrites the display word.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_seg7_scan_if.slave  bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST    = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    // With no gap the FSM lives in S_DRIVE permanently.
    localparam state_t RST_STATE = (BLANK_CYC == 0) ? S_DRIVE : S_BLANK;

    logic [15:0]   disp_reg;
    logic [PW-1:0] prescale;
    logic [1:0]    idx;
    state_t        state;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic          wrap;
    logic [3:0]    cur_nibble;
    logic          lz_blank;
    logic [6:0]    dec_seg;

    assign wrap       = (prescale == PS_LAST);
    assign cur_nibble = disp_reg[{idx, 2'b00} +: 4];

    // Display word: replaced on each strobe, independent of scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= 16'h0000;
        end else if (bus.bcd_valid) begin
            disp_reg <= bus.bcd;
        end
    end

    // Slot timer and digit index; index steps only on the slot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            idx      <= 2'd0;
        end else if (wrap) begin
            prescale <= '0;
            idx      <= idx + 2'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Leading-zero suppression: digit k blanks when it and every higher nibble is zero.
    always_comb begin
        lz_blank = 1'b0;
        case (idx)
            2'd1: lz_blank = (disp_reg[15:4]  == 12'h000);
            2'd2: lz_blank = (disp_reg[15:8]  == 8'h00);
            2'd3: lz_blank = (disp_reg[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & bus.blank_lz;
    end

    bcd_to_seg7 u_dec (
        .nibble (cur_nibble),
        .blank  (lz_blank),
        .seg    (dec_seg)
    );

    // Slot FSM with registered drive outputs; reset turns all anodes off at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            case (state)
                S_BLANK: begin
                    an_q  <= 4'b1111;
                    seg_q <= SEG_BLANK;
                    dp_q  <= 1'b1;
                    if (prescale == BLANK_LAST) begin
                        state <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    an_q  <= ~(4'b0001 << idx);
                    seg_q <= dec_seg;
                    dp_q  <= ~bus.dp_mask[idx];
                    if (wrap && (BLANK_CYC != 0)) begin
                        state <= S_BLANK;
                    end
                end
                default: begin
                    state <= RST_STATE;
                    an_q  <= 4'b1111;
                    seg_q <= SEG_BLANK;
                    dp_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Purpose: scoreboard bench for bcd_seg7_scan with SCAN_DIV=8, BLANK_CYC=2.
// Latency: expected slot contents queued at load time, checked at each slot start.
// Backpressure: n/a.
module tb_bcd_seg7_scan;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GD = 7'b0111111;
    localparam logic [6:0] GB = 7'h7F;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    exp_t q[$];

    bcd_seg7_scan_if bus ();

    bcd_seg7_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Polls at posedge+1 until the anodes show v.
    task automatic wait_an(input logic [3:0] v);
        int n;
        n = 0;
        while (bus.an !== v && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.an !== v) timeout("wait_an");
    endtask

    // Waits for the first drive cycle of the slot with anodes v.
    task automatic wait_slot_start(input logic [3:0] v);
        wait_an(4'b1111);
        wait_an(v);
    endtask

    task automatic wait_q_empty();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            timeout("wait_q_empty");
            q.delete();
        end
    endtask

    task automatic push4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic [3:0] dpx);
        q.push_back({4'b1110, s0, dpx[0]});
        q.push_back({4'b1101, s1, dpx[1]});
        q.push_back({4'b1011, s2, dpx[2]});
        q.push_back({4'b0111, s3, dpx[3]});
    endtask

    // Loads during the digit-3 slot so the next full rotation shows the new word.
    task automatic load_at_d3(input logic [15:0] v, input logic blz, input logic [3:0] dpm,
                              input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpx);
        wait_q_empty();
        wait_an(4'b0111);
        bus.bcd       = v;
        bus.bcd_valid = 1'b1;
        bus.blank_lz  = blz;
        bus.dp_mask   = dpm;
        push4(s0, s1, s2, s3, dpx);
        @(posedge clk);
        #1;
        bus.bcd_valid = 1'b0;
    endtask

    // Monitor: at each slot start pop and compare; check drive and gap lengths of checked slots.
    logic [3:0] prev_an;
    int         drive_len;
    int         gap_len;
    bit         checking;
    bit         first_after_rst;
    exp_t       e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_an         = 4'b1111;
            drive_len       = 0;
            gap_len         = 0;
            checking        = 1'b0;
            first_after_rst = 1'b1;
        end else begin
            if (bus.an != prev_an && prev_an != 4'b1111) begin
                if (checking) chk("drive_len", 16'(drive_len), 16'd6);
                checking = 1'b0;
            end
            if (bus.an != 4'b1111 && bus.an != prev_an) begin
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("slot_an", {12'h0, bus.an}, {12'h0, e.an});
                    chk("slot_seg", {9'h0, bus.seg}, {9'h0, e.seg});
                    chk("slot_dp", {15'h0, bus.dp}, {15'h0, e.dp});
                    if (!first_after_rst) chk("gap_len", 16'(gap_len), 16'd2);
                    checking = 1'b1;
                end
                first_after_rst = 1'b0;
                drive_len = 0;
                gap_len   = 0;
            end
            if (bus.an == 4'b1111) begin
                gap_len++;
                if (checking || q.size() != 0) begin
                    if (bus.seg !== GB || bus.dp !== 1'b1) begin
                        chk("gap_blank", {8'h0, bus.seg, bus.dp}, {8'h0, GB, 1'b1});
                    end
                end
            end else begin
                drive_len++;
            end
            prev_an = bus.an;
        end
    end

    initial begin
        checks = 0;
        fails  = 0;
        rst_n         = 1'b0;
        bus.bcd       = 16'h0000;
        bus.bcd_valid = 1'b0;
        bus.blank_lz  = 1'b0;
        bus.dp_mask   = 4'b0000;

        // Reset state, then power-up contents: all zeros, no blanking.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", {12'h0, bus.an}, 16'h000F);
        chk("rst_seg", {9'h0, bus.seg}, 16'h007F);
        chk("rst_dp", {15'h0, bus.dp}, 16'h0001);
        push4(G0, G0, G0, G0, 4'b1111);
        rst_n = 1'b1;

        // Directed words with hand-derived glyphs.
        load_at_d3(16'h1234, 1'b0, 4'b0000, G4, G3, G2, G1, 4'b1111);
        load_at_d3(16'h0042, 1'b1, 4'b0000, G2, G4, GB, GB, 4'b1111);
        load_at_d3(16'h0000, 1'b1, 4'b0000, G0, GB, GB, GB, 4'b1111);
        load_at_d3(16'h0A05, 1'b1, 4'b0000, G5, G0, GD, GB, 4'b1111);
        load_at_d3(16'h0A05, 1'b0, 4'b0000, G5, G0, GD, G0, 4'b1111);
        load_at_d3(16'h0042, 1'b1, 4'b1000, G2, G4, GB, GB, 4'b0111);
        load_at_d3(16'h1234, 1'b0, 4'b0100, G4, G3, G2, G1, 4'b1011);
        wait_q_empty();

        // Strobe on the wrap edge: last drive cycle keeps the old digit, next rotation is new.
        wait_slot_start(4'b0111);
        repeat (4) @(posedge clk);
        #1;
        bus.bcd       = 16'h9876;
        bus.bcd_valid = 1'b1;
        bus.dp_mask   = 4'b0000;
        push4(G6, G7, G8, G9, 4'b1111);
        @(posedge clk);
        #1;
        bus.bcd_valid = 1'b0;
        chk("wrap_an", {12'h0, bus.an}, 16'h0007);
        chk("wrap_seg_old", {9'h0, bus.seg}, {9'h0, G1});
        @(posedge clk);
        #1;
        chk("wrap_gap_an", {12'h0, bus.an}, 16'h000F);
        wait_q_empty();

        // Mid-slot strobe: next output still old, the one after shows the new word.
        wait_slot_start(4'b1110);
        bus.bcd       = 16'h0005;
        bus.bcd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bcd_valid = 1'b0;
        chk("load_n1_seg", {9'h0, bus.seg}, {9'h0, G6});
        @(posedge clk);
        #1;
        chk("load_n2_seg", {9'h0, bus.seg}, {9'h0, G5});
        chk("load_n2_an", {12'h0, bus.an}, 16'h000E);

        // Asynchronous reset in the middle of digit 2.
        wait_slot_start(4'b1011);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_an", {12'h0, bus.an}, 16'h000F);
        chk("midrst_seg", {9'h0, bus.seg}, 16'h007F);
        chk("midrst_dp", {15'h0, bus.dp}, 16'h0001);
        q.delete();
        push4(G0, G0, G0, G0, 4'b1111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_q_empty();
        wait_an(4'b1111);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
